// File: rtl/spike_arb_pkg.sv
// Shared types and the round-robin pick helper for the spike arbiter.
package spike_arb_pkg;

    localparam int MAX_SRC   = 32;
    localparam int SRC_IDX_W = 5;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, ACK_SRC} arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [SRC_IDX_W-1:0] idx;
    } pick_t;

    // Scan offsets from high to low so the lowest offset from ptr wins.
    function automatic pick_t rr_pick(input logic [MAX_SRC-1:0]   req,
                                      input logic [SRC_IDX_W-1:0] ptr,
                                      input int                   n);
        pick_t p;
        int    i;
        p = '0;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < n) begin
                i = int'(ptr) + k;
                if (i >= n) i = i - n;
                if (req[i]) begin
                    p.valid = 1'b1;
                    p.idx   = SRC_IDX_W'(i);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sync_vec.sv
// Bit-vector multi-flop synchroniser, each bit synchronised independently.
// Latency: STAGES clock edges.
// Backpressure: none; samples every cycle.
module sync_vec #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int s = 1; s < STAGES; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/spike_arbiter.sv
// Round-robin arbiter sharing one neuron's four-phase input channel among N_SRC sources.
// Latency: SYNC_STAGES+1 edges per handshake edge; minimum transfer 4*(SYNC_STAGES+1).
// Backpressure: a source waits with req high until granted; neuron ack paces each transfer.
module spike_arbiter
    import spike_arb_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_req,
    input  logic [N_SRC-1:0]         src_data,
    output logic [N_SRC-1:0]         src_ack,
    output logic                     nrn_req,
    output logic                     nrn_data,
    input  logic                     nrn_ack,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int GW = $clog2(N_SRC);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [N_SRC-1:0] s_req;
    logic             s_ack;

    sync_vec #(.WIDTH(N_SRC), .STAGES(SYNC_STAGES)) u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (src_req),
        .q   (s_req)
    );

    sync_vec #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d   (nrn_ack),
        .q   (s_ack)
    );

    arb_state_t       state, state_nxt;
    logic [GW-1:0]    ptr, ptr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [N_SRC-1:0] src_ack_nxt;
    logic             nrn_req_nxt, nrn_data_nxt, err_nxt;
    logic [GW-1:0]    grant_nxt, win;
    pick_t            pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            src_ack     <= '0;
            nrn_req     <= 1'b0;
            nrn_data    <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            src_ack     <= src_ack_nxt;
            nrn_req     <= nrn_req_nxt;
            nrn_data    <= nrn_data_nxt;
            grant_id    <= grant_nxt;
            busy        <= (state_nxt != IDLE);
            err_timeout <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        src_ack_nxt  = src_ack;
        nrn_req_nxt  = nrn_req;
        nrn_data_nxt = nrn_data;
        grant_nxt    = grant_id;
        err_nxt      = err_timeout;
        pick         = rr_pick(MAX_SRC'(s_req), SRC_IDX_W'(ptr), N_SRC);
        win          = GW'(pick.idx);

        case (state)
            IDLE: begin
                if (pick.valid) begin
                    grant_nxt    = win;
                    nrn_data_nxt = src_data[win];
                    nrn_req_nxt  = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                // Counter saturates; the flag lands on the edge where it reaches TIMEOUT.
                if (cnt != CW'(TIMEOUT)) cnt_nxt = cnt + 1'b1;
                if (cnt >= CW'(TIMEOUT - 1)) err_nxt = 1'b1;
                if (s_ack) begin
                    nrn_req_nxt = 1'b0;
                    state_nxt   = RELEASE;
                end
            end
            RELEASE: begin
                if (!s_ack) begin
                    src_ack_nxt[grant_id] = 1'b1;
                    state_nxt             = ACK_SRC;
                end
            end
            ACK_SRC: begin
                if (!s_req[grant_id]) begin
                    src_ack_nxt = '0;
                    ptr_nxt     = (grant_id == GW'(N_SRC - 1)) ? '0 : grant_id + 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
